mem_stage: RTL

Memory-access stage of the 5-step CPU pipeline, directly downstream of the execute stage. Takes the executed instruction, ALU result and store data, performs LOAD/STORE accesses on a req/ack data-memory bus, and registers the instruction and result for write-back. While an access is outstanding it raises `stall` to freeze the upstream stages.

---
 rtl/mem_stage.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/mem_stage.sv
// mem_stage: pipeline memory-access stage that issues LOAD/STORE on a req/ack bus and stalls upstream meanwhile.
// Define MEM_TIMEOUT_EN to abort an access after TIMEOUT_CYCLES WAIT cycles without d_ack (sticky mem_err).

`ifndef EXEC
`define EXEC 2'b01
`endif
`ifndef NOP
`define NOP 5'b00000
`endif
`ifndef LOAD
`define LOAD 5'b00010
`endif
`ifndef STORE
`define STORE 5'b00011
`endif

module mem_stage #(
  parameter int TIMEOUT_CYCLES = 15
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [1:0]  state,
  input  logic [15:0] mem_ir,
  input  logic [15:0] reg_C,
  input  logic [15:0] smdr1,
  input  logic        dw,
  input  logic [15:0] d_rdata,
  input  logic        d_ack,
  output logic        d_req,
  output logic        d_we,
  output logic [15:0] d_addr,
  output logic [15:0] d_wdata,
  output logic [15:0] wb_ir,
  output logic [15:0] reg_C1,
  output logic        stall,
  output logic        mem_err
);

  typedef enum logic {IDLE, WAIT} fsm_e;

  fsm_e        fsm_q, fsm_d;
  logic        req_q, req_d, we_q, we_d;
  logic [15:0] addr_q, addr_d, wdata_q, wdata_d;
  logic [15:0] wb_ir_q, wb_ir_d, res_q, res_d, ir_q, ir_d;
  logic        exec_now, is_load, is_store, mem_op, launch, timeout_hit, stall_c;

  assign exec_now = (state == `EXEC);
  assign is_load  = (mem_ir[15:11] == `LOAD);
  assign is_store = (mem_ir[15:11] == `STORE);
  assign mem_op   = is_load | (is_store & dw);
  assign launch   = (fsm_q == IDLE) && exec_now && mem_op;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) fsm_q <= IDLE;
    else        fsm_q <= fsm_d;
  end

  always_comb begin
    fsm_d = fsm_q;
    case (fsm_q)
      IDLE:    if (launch) fsm_d = WAIT;
      WAIT:    if (d_ack || timeout_hit) fsm_d = IDLE;
      default: fsm_d = IDLE;
    endcase
  end

  // A timeout abort drops stall in its own cycle so upstream can move on.
  always_comb begin
    req_d   = req_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    wb_ir_d = wb_ir_q;
    res_d   = res_q;
    ir_d    = ir_q;
    stall_c = 1'b0;
    case (fsm_q)
      IDLE: begin
        if (exec_now) begin
          if (mem_op) begin
            req_d   = 1'b1;
            we_d    = is_store;
            addr_d  = reg_C;
            wdata_d = smdr1;
            ir_d    = mem_ir;
            wb_ir_d = {`NOP, 11'b0};
            stall_c = 1'b1;
          end else begin
            wb_ir_d = mem_ir;
            res_d   = reg_C;
          end
        end
      end
      WAIT: begin
        if (d_ack) begin
          req_d   = 1'b0;
          we_d    = 1'b0;
          wb_ir_d = ir_q;
          res_d   = (ir_q[15:11] == `LOAD) ? d_rdata : addr_q;
        end else if (timeout_hit) begin
          req_d   = 1'b0;
          we_d    = 1'b0;
          wb_ir_d = {`NOP, 11'b0};
        end else begin
          stall_c = 1'b1;
        end
      end
      default: stall_c = 1'b0;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      wb_ir_q <= '0;
      res_q   <= '0;
      ir_q    <= '0;
    end else begin
      req_q   <= req_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wb_ir_q <= wb_ir_d;
      res_q   <= res_d;
      ir_q    <= ir_d;
    end
  end

`ifdef MEM_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;

  // The limit is reached in the WAIT cycle that would be the TIMEOUT_CYCLES-th without an ack.
  assign timeout_hit = (fsm_q == WAIT) && !d_ack && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

  always_comb begin
    cnt_d = cnt_q;
    err_d = err_q;
    if (launch)
      cnt_d = '0;
    else if ((fsm_q == WAIT) && !d_ack)
      cnt_d = cnt_q + 1'b1;
    if (timeout_hit) err_d = 1'b1;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  assign mem_err = err_q;
`else
  assign timeout_hit = 1'b0;
  assign mem_err     = 1'b0;
`endif

  assign d_req   = req_q;
  assign d_we    = we_q;
  assign d_addr  = addr_q;
  assign d_wdata = wdata_q;
  assign wb_ir   = wb_ir_q;
  assign reg_C1  = res_q;
  // Gating with reset keeps stall low while reset is held, even if a launch is presented.
  assign stall   = stall_c & reset;

endmodule
